pc_fetch_unit: RTL and testbench

- Front-end counterpart to the instruction decoder: it supplies the 32-bit instruction and the 5-bit status to the control unit.
- It consumes the PC-related control-word fields the decoder produces: PS, K, NS, EN_PC, SL.
- It owns the program counter, the instruction-memory fetch handshake, the registered V/C/N/Z flags, multi-cycle instruction holding and a retired-instruction counter.

---
 rtl/pc_fetch_unit_if.sv | 21 ++
 rtl/pc_fetch_unit.sv | 90 +++++++++
 tb/tb_pc_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake: request held until the response cycle.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction fetch, V/C/N/Z flag register and retired counter.
// One cycle minimum fetch latency, unbounded memory wait states; EXEC repeats while NS=1.
module pc_fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  pc_fetch_unit_if.master      imem,
  output logic [31:0]          instruction,
  output logic [4:0]           status,
  output logic                 exec,
  input  logic [1:0]           PS,
  input  logic [63:0]          K,
  input  logic                 NS,
  input  logic                 EN_PC,
  input  logic                 SL,
  input  logic [3:0]           alu_flags,
  input  logic                 alu_zero,
  input  logic [63:0]          bus_in,
  output logic [63:0]          bus_out,
  output logic [63:0]          pc,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t      state;
  logic        req;
  logic [3:0]  flags;
  logic [63:0] pc_plus4;
  logic [63:0] pc_next;

  assign pc_plus4       = pc + 64'd4;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign status         = {flags, alu_zero};
  assign bus_out        = (EN_PC && exec) ? pc_plus4 : 64'h0;

  // K is a word offset relative to the following instruction
  always_comb begin
    pc_next = pc;
    case (PS)
      2'b00:   pc_next = pc;
      2'b01:   pc_next = pc_plus4;
      2'b10:   pc_next = {bus_in[63:2], 2'b00};
      default: pc_next = pc_plus4 + (K << 2);
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= PC_RESET;
      req         <= 1'b0;
      instruction <= 32'h0;
      flags       <= 4'h0;
      retired     <= '0;
      exec        <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!req) begin
            req <= 1'b1;
          end else if (imem.imem_valid) begin
            instruction <= imem.imem_data;
            req         <= 1'b0;
            state       <= EXEC;
            exec        <= 1'b1;
          end
        end
        EXEC: begin
          if (SL) flags <= alu_flags;
          pc <= pc_next;
          if (!NS) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            state   <= FETCH;
            exec    <= 1'b0;
            req     <= 1'b1;
          end
        end
        default: begin
          state <= FETCH;
          exec  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch, branches, BL, flags, reset and wrap.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic        exec;
  logic [1:0]  PS;
  logic [63:0] K;
  logic        NS, EN_PC, SL;
  logic [3:0]  alu_flags;
  logic        alu_zero;
  logic [63:0] bus_in;
  logic [63:0] bus_out;
  logic [63:0] pc;
  logic [31:0] retired;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_fetch_unit_if imem_bus ();

  pc_fetch_unit #(.PC_RESET(64'h0), .CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem_bus.master),
    .instruction (instruction),
    .status      (status),
    .exec        (exec),
    .PS          (PS),
    .K           (K),
    .NS          (NS),
    .EN_PC       (EN_PC),
    .SL          (SL),
    .alu_flags   (alu_flags),
    .alu_zero    (alu_zero),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .pc          (pc),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ctl(input logic [1:0] ps, input logic [63:0] k, input logic ns,
                         input logic en, input logic sl, input logic [3:0] fl,
                         input logic [63:0] bi);
    PS = ps; K = k; NS = ns; EN_PC = en; SL = sl; alu_flags = fl; bus_in = bi;
  endtask

  // Waits for the request, checks the address, inserts wait states, then answers.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data, input int waits);
    int budget = 0;
    logic [31:0] prev;
    while (imem_bus.imem_req !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (imem_bus.imem_req !== 1'b1 || exec !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_req: req=%b exec=%b after %0d cycles, required req=1 exec=0",
               imem_bus.imem_req, exec, budget);
    end
    n_cmp++;
    if (imem_bus.imem_addr !== addr) begin
      n_fail++;
      $display("FAIL fetch_addr: got %h required %h", imem_bus.imem_addr, addr);
    end
    prev = instruction;
    for (int w = 0; w < waits; w++) begin
      tick();
      n_cmp++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== addr || instruction !== prev) begin
        n_fail++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h instr=%h required req=1 addr=%h instr=%h",
                 w, imem_bus.imem_req, imem_bus.imem_addr, instruction, 1'b1, addr, prev);
      end
    end
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_data  = data;
    tick();
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_data  = $urandom;
    n_cmp++;
    if (exec !== 1'b1 || instruction !== data || imem_bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_capture: exec=%b instr=%h req=%b required exec=1 instr=%h req=0",
               exec, instruction, imem_bus.imem_req, data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_data  = 32'hDEAD_BEEF;
    set_ctl(2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0);
    alu_zero = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (pc !== 64'h0 || imem_bus.imem_req !== 1'b0 || instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc_req_instr: pc=%h req=%b instr=%h required 0/0/0",
               pc, imem_bus.imem_req, instruction);
    end
    n_cmp++;
    if (status !== 5'h0 || retired !== 32'h0 || exec !== 1'b0 || bus_out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_status_cnt: status=%b retired=%0d exec=%b bus_out=%h required 0",
               status, retired, exec, bus_out);
    end
    imem_bus.imem_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_straight_line();
    for (int i = 0; i < 3; i++) begin
      do_fetch(64'(4 * i), 32'h1000_0000 + 32'(i), 0);
      set_ctl(2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0);
      tick();
      n_cmp++;
      if (exec !== 1'b0 || pc !== 64'(4 * (i + 1))) begin
        n_fail++;
        $display("FAIL straight_exec[%0d]: exec=%b pc=%h required exec=0 pc=%h",
                 i, exec, pc, 64'(4 * (i + 1)));
      end
    end
    n_cmp++;
    if (retired !== 32'd3) begin
      n_fail++;
      $display("FAIL straight_retired: got %0d required 3", retired);
    end
  endtask

  task automatic test_wait_states();
    do_fetch(64'hC, 32'hA5A5_0003, 5);
    set_ctl(2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h102);
    tick();
    n_cmp++;
    if (pc !== 64'h100) begin
      n_fail++;
      $display("FAIL wait_br_pc: got %h required 100", pc);
    end
  endtask

  task automatic test_branch();
    do_fetch(64'h100, 32'hB000_0001, 1);
    set_ctl(2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0);
    tick();
    n_cmp++;
    if (pc !== 64'hFC) begin
      n_fail++;
      $display("FAIL cbranch_pc: got %h required fc", pc);
    end
    do_fetch(64'hFC, 32'hB000_0002, 0);
    set_ctl(2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h2003);
    tick();
    n_cmp++;
    if (pc !== 64'h2000 || retired !== 32'd6) begin
      n_fail++;
      $display("FAIL br_pc: pc=%h retired=%0d required pc=2000 retired=6", pc, retired);
    end
  endtask

  task automatic test_bl();
    do_fetch(64'h2000, 32'hC000_0000, 0);
    set_ctl(2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h40);
    tick();
    do_fetch(64'h40, 32'hC000_0001, 0);
    set_ctl(2'b00, 64'h0, 1'b1, 1'b1, 1'b0, 4'h0, 64'h0);
    #1;
    n_cmp++;
    if (bus_out !== 64'h44) begin
      n_fail++;
      $display("FAIL bl_link: bus_out=%h required 44", bus_out);
    end
    tick();
    n_cmp++;
    if (pc !== 64'h40 || exec !== 1'b1 || imem_bus.imem_req !== 1'b0 ||
        retired !== 32'd7 || instruction !== 32'hC000_0001) begin
      n_fail++;
      $display("FAIL bl_cycle1: pc=%h exec=%b req=%b retired=%0d instr=%h required 40/1/0/7/c0000001",
               pc, exec, imem_bus.imem_req, retired, instruction);
    end
    set_ctl(2'b11, 64'h4, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0);
    tick();
    n_cmp++;
    if (pc !== 64'h54 || retired !== 32'd8 || exec !== 1'b0) begin
      n_fail++;
      $display("FAIL bl_cycle2: pc=%h retired=%0d exec=%b required 54/8/0", pc, retired, exec);
    end
    EN_PC = 1'b1;
    #1;
    n_cmp++;
    if (bus_out !== 64'h0) begin
      n_fail++;
      $display("FAIL bl_link_fetch: bus_out=%h required 0 outside exec", bus_out);
    end
    EN_PC = 1'b0;
  endtask

  task automatic test_flags();
    do_fetch(64'h54, 32'hD000_0000, 0);
    set_ctl(2'b01, 64'h0, 1'b0, 1'b0, 1'b1, 4'b1010, 64'h0);
    tick();
    n_cmp++;
    if (status[4:1] !== 4'b1010) begin
      n_fail++;
      $display("FAIL flags_latch: got %b required 1010", status[4:1]);
    end
    do_fetch(64'h58, 32'hD000_0001, 0);
    set_ctl(2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 4'b0101, 64'h0);
    tick();
    n_cmp++;
    if (status[4:1] !== 4'b1010 || retired !== 32'd10) begin
      n_fail++;
      $display("FAIL flags_hold: flags=%b retired=%0d required 1010/10", status[4:1], retired);
    end
    alu_zero = 1'b1;
    #1;
    n_cmp++;
    if (status[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL zz_high: got %b required 1", status[0]);
    end
    alu_zero = 1'b0;
    #1;
    n_cmp++;
    if (status[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zz_low: got %b required 0", status[0]);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    do_fetch(64'h5C, 32'hE000_0000, 0);
    set_ctl(2'b11, 64'h8, 1'b0, 1'b0, 1'b1, 4'b1111, 64'h0);
    reset = 1'b0;
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_data  = 32'h1234_5678;
    tick();
    tick();
    n_cmp++;
    if (pc !== 64'h0 || status[4:1] !== 4'h0 || retired !== 32'd0 || exec !== 1'b0 ||
        imem_bus.imem_req !== 1'b0 || instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: pc=%h flags=%b retired=%0d exec=%b req=%b instr=%h required all 0",
               pc, status[4:1], retired, exec, imem_bus.imem_req, instruction);
    end
    imem_bus.imem_valid = 1'b0;
    reset = 1'b1;
    SL = 1'b0;
    do_fetch(64'h0, 32'hF000_0000, 0);
    set_ctl(2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    n_cmp++;
    if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++;
      $display("FAIL br_align: got %h required fffffffffffffffc", pc);
    end
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hF000_0001, 0);
    set_ctl(2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0);
    tick();
    n_cmp++;
    if (pc !== 64'h0 || retired !== 32'd2) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h retired=%0d required 0/2", pc, retired);
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_wait_states();
    test_branch();
    test_bl();
    test_flags();
    test_reset_mid_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
